pcap_framer: RTL

- Downstream stage of the packet-memory read controller; drains the 32-bit word FIFO that the controller fills.
- Wraps each packet as a pcap record: a 4-word record header, then the payload words.
- Emits the record on a 32-bit streaming source with valid/ready, start-of-packet and end-of-packet markers, toward the capture sink.
- Truncates payload to SNAPLEN. FIFO words beyond the truncated payload are popped and discarded, so the FIFO stays word-aligned for the next packet.

---
 rtl/pcap_framer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pcap_framer.sv
// pcap record framer: drains the packet word FIFO and emits header + truncated payload on a valid/ready stream.
// Optional PCAP_GLOBAL_HDR_EN emits the 6-word pcap global header before the first record after reset.
module pcap_framer #(
    parameter int                 LEN_W   = 16,
    parameter logic [LEN_W-1:0]   SNAPLEN = 16'd1514
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pkt_start,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic [31:0]      ts_sec,
    input  logic [31:0]      ts_usec,
    input  logic [31:0]      fifo_q,
    input  logic             fifo_empty,
    output logic             fifo_rdreq,
    output logic [31:0]      st_data,
    output logic             st_valid,
    input  logic             st_ready,
    output logic             st_sop,
    output logic             st_eop,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {
        IDLE,
`ifdef PCAP_GLOBAL_HDR_EN
        GHDR,
`endif
        HDR, PAY, DRAIN, DONE
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       idx;
    logic [31:0]      sec_r, usec_r, incl_r, orig_r;
    logic [LEN_W-1:0] pop_left, out_left, drain_left;
    logic             rd_pend, hold_vld;
    logic [31:0]      hold_data;
`ifdef PCAP_GLOBAL_HDR_EN
    logic             ghdr_seen;
`endif

    logic [LEN_W-1:0] incl_len, pay_words, fifo_words;
    logic [LEN_W:0]   pay_sum, fifo_sum;
    logic             xfer, hdr_last, pay_load, out_other, slot_ok;
    logic             rdreq_pay, rdreq_drain;

    assign incl_len   = (pkt_len > SNAPLEN) ? SNAPLEN : pkt_len;
    assign pay_sum    = (LEN_W+1)'(incl_len) + (LEN_W+1)'(3);
    assign fifo_sum   = (LEN_W+1)'(pkt_len) + (LEN_W+1)'(3);
    assign pay_words  = LEN_W'(pay_sum >> 2);
    assign fifo_words = LEN_W'(fifo_sum >> 2);

    assign xfer     = st_valid && st_ready;
    assign hdr_last = (state == HDR) && (idx == 3'd3) && xfer;
    assign pay_load = ((state == PAY) && (!st_valid || xfer)) || (hdr_last && out_left != '0);

    // Two payload slots (output register + hold); in-flight reads count against them.
    assign out_other   = (state == PAY) ? (st_valid && !xfer) : !hdr_last;
    assign slot_ok     = !(hold_vld && rd_pend) && !((hold_vld || rd_pend) && out_other);
    assign rdreq_pay   = ((state == HDR) || (state == PAY)) && !fifo_empty && (pop_left != '0) && slot_ok;
    assign rdreq_drain = (state == DRAIN) && !fifo_empty && (drain_left != '0);

    function automatic logic [31:0] hdr_word(input logic [2:0] i);
        case (i)
            3'd0:    hdr_word = sec_r;
            3'd1:    hdr_word = usec_r;
            3'd2:    hdr_word = incl_r;
            default: hdr_word = orig_r;
        endcase
    endfunction

`ifdef PCAP_GLOBAL_HDR_EN
    function automatic logic [31:0] ghdr_word(input logic [2:0] i);
        case (i)
            3'd0:    ghdr_word = 32'hA1B2C3D4;
            3'd1:    ghdr_word = 32'h00040002;
            3'd4:    ghdr_word = 32'(SNAPLEN);
            3'd5:    ghdr_word = 32'd1;
            default: ghdr_word = 32'd0;
        endcase
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pkt_start) begin
`ifdef PCAP_GLOBAL_HDR_EN
                state_nxt = ghdr_seen ? HDR : GHDR;
`else
                state_nxt = HDR;
`endif
            end
`ifdef PCAP_GLOBAL_HDR_EN
            GHDR:  if (xfer && idx == 3'd5) state_nxt = HDR;
`endif
            HDR:   if (hdr_last) state_nxt = (out_left != '0) ? PAY : DRAIN;
            PAY:   if (xfer && st_eop) state_nxt = DRAIN;
            DRAIN: if (drain_left == '0 || (drain_left == LEN_W'(1) && rdreq_drain)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE) && (state != DONE);
        done       = (state == DONE);
        fifo_rdreq = rdreq_pay || rdreq_drain;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx <= '0; sec_r <= '0; usec_r <= '0; incl_r <= '0; orig_r <= '0;
            pop_left <= '0; out_left <= '0; drain_left <= '0;
            rd_pend <= 1'b0; hold_vld <= 1'b0; hold_data <= '0;
            st_data <= '0; st_valid <= 1'b0; st_sop <= 1'b0; st_eop <= 1'b0;
`ifdef PCAP_GLOBAL_HDR_EN
            ghdr_seen <= 1'b0;
`endif
        end else begin
            rd_pend <= rdreq_pay;
            if (rdreq_pay)   pop_left   <= pop_left - LEN_W'(1);
            if (rdreq_drain) drain_left <= drain_left - LEN_W'(1);

            if (pay_load && hold_vld) begin
                hold_vld  <= rd_pend;
                hold_data <= fifo_q;
            end else if (!pay_load && rd_pend) begin
                hold_vld  <= 1'b1;
                hold_data <= fifo_q;
            end

            case (state)
                IDLE: if (pkt_start) begin
                    sec_r      <= ts_sec;
                    usec_r     <= ts_usec;
                    incl_r     <= 32'(incl_len);
                    orig_r     <= 32'(pkt_len);
                    pop_left   <= pay_words;
                    out_left   <= pay_words;
                    drain_left <= fifo_words - pay_words;
                    idx        <= '0;
                    st_valid   <= 1'b1;
                    st_sop     <= 1'b1;
                    st_eop     <= 1'b0;
`ifdef PCAP_GLOBAL_HDR_EN
                    ghdr_seen  <= 1'b1;
                    st_data    <= ghdr_seen ? ts_sec : 32'hA1B2C3D4;
`else
                    st_data    <= ts_sec;
`endif
                end
`ifdef PCAP_GLOBAL_HDR_EN
                GHDR: if (xfer) begin
                    idx     <= (idx == 3'd5) ? 3'd0 : 3'(idx + 3'd1);
                    st_data <= (idx == 3'd5) ? sec_r : ghdr_word(3'(idx + 3'd1));
                    st_sop  <= (idx == 3'd5);
                    st_eop  <= (idx == 3'd4);
                end
`endif
                HDR: if (xfer && idx != 3'd3) begin
                    idx     <= 3'(idx + 3'd1);
                    st_data <= hdr_word(3'(idx + 3'd1));
                    st_sop  <= 1'b0;
                    st_eop  <= (idx == 3'd2) && (out_left == '0);
                end
                default: ;
            endcase

            // Payload loads prefer the hold register so words leave in arrival order.
            if (pay_load) begin
                if (hold_vld || rd_pend) begin
                    st_valid <= 1'b1;
                    st_data  <= hold_vld ? hold_data : fifo_q;
                    st_sop   <= 1'b0;
                    st_eop   <= (out_left == LEN_W'(1));
                    out_left <= out_left - LEN_W'(1);
                end else begin
                    st_valid <= 1'b0;
                    st_sop   <= 1'b0;
                    st_eop   <= 1'b0;
                end
            end else if (xfer && st_eop && state == HDR) begin
                st_valid <= 1'b0;
                st_eop   <= 1'b0;
            end
        end
    end
endmodule
